// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter
//   Shares one single-port, synchronous-read video RAM between the display
//   fetch path (absolute priority) and a FIFO-buffered host write port that
//   drains only in cycles the display does not need the memory.
//
// Ports
//   ck, reset        clock; synchronous active-high reset
//   active           horizontal visible-area flag
//   position         horizontal pixel index (valid while active)
//   newline          one-cycle pulse at end of each line
//   frame_start      one-cycle pulse before the first line of a frame
//   row_active       current line is inside the vertical visible area
//   host_valid/ready host write handshake (ready = !full, 0 in reset)
//   host_addr/data   host write address / data
//   mem_addr/we/wdata  RAM command, combinational from the slot decision
//   mem_rdata        RAM read data, valid one cycle after the address
//   pix_data/valid   pixel output, two cycles after the display read
//   fifo_level       host FIFO occupancy
//   drop_count       saturating count of discarded out-of-range host writes
module vga_vram_arbiter #(
  parameter int unsigned H_VISIBLE  = 800,
  parameter int unsigned V_VISIBLE  = 600,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          ck,
  input  logic                          reset,
  input  logic                          active,
  input  logic [11:0]                   position,
  input  logic                          newline,
  input  logic                          frame_start,
  input  logic                          row_active,
  input  logic                          host_valid,
  output logic                          host_ready,
  input  logic [ADDR_W-1:0]             host_addr,
  input  logic [DATA_W-1:0]             host_data,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic                          mem_we,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [DATA_W-1:0]             pix_data,
  output logic                          pix_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_count
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W:0]     PIX_TOTAL = (ADDR_W+1)'(H_VISIBLE * V_VISIBLE);
  localparam logic [ADDR_W-1:0]   LINE_STEP = ADDR_W'(H_VISIBLE);
  localparam logic [LVL_W-1:0]    LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]    PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_DISPLAY,
    SLOT_DRAIN
  } slot_t;

  slot_t              slot;
  logic [ADDR_W-1:0]  fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]  fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   level;
  logic [ADDR_W-1:0]  line_base;
  logic               disp_d1;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_data;
  logic               head_in_range;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign full          = (level == LVL_FULL);
  assign empty         = (level == '0);
  assign host_ready    = ~reset & ~full;
  // A full FIFO never accepts, even when the head pops in the same cycle.
  assign push          = host_valid & host_ready;
  assign head_addr     = fifo_addr[rd_ptr];
  assign head_data     = fifo_data[rd_ptr];
  assign head_in_range = ({1'b0, head_addr} < PIX_TOTAL);
  assign fifo_level    = level;

  // Display owns the RAM whenever it is in the visible area; the host only
  // gets leftover cycles, so a display read can never race a queued write.
  always_comb begin
    slot = SLOT_IDLE;
    if (reset)
      slot = SLOT_IDLE;
    else if (active && row_active)
      slot = SLOT_DISPLAY;
    else if (!empty)
      slot = SLOT_DRAIN;
  end

  assign pop = (slot == SLOT_DRAIN);

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    unique case (slot)
      SLOT_DISPLAY: mem_addr = line_base + ADDR_W'(position);
      SLOT_DRAIN: begin
        // Out-of-range entries still pop, but never reach the RAM.
        if (head_in_range) begin
          mem_addr  = head_addr;
          mem_we    = 1'b1;
          mem_wdata = head_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ck) begin
    if (push) begin
      fifo_addr[wr_ptr] <= host_addr;
      fifo_data[wr_ptr] <= host_data;
    end
  end

  always_ff @(posedge ck) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      line_base  <= '0;
      drop_count <= '0;
      disp_d1    <= 1'b0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
    end else begin
      if (push)
        wr_ptr <= ptr_next(wr_ptr);
      if (pop)
        rd_ptr <= ptr_next(rd_ptr);

      if (push && !pop)
        level <= level + LVL_W'(1);
      else if (pop && !push)
        level <= level - LVL_W'(1);

      // frame_start has precedence over a coincident newline.
      if (frame_start)
        line_base <= '0;
      else if (newline && row_active)
        line_base <= line_base + LINE_STEP;

      if (pop && !head_in_range && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;

      // Read issued in t, RAM data in t+1, pixel register visible in t+2.
      disp_d1   <= (slot == SLOT_DISPLAY);
      pix_valid <= disp_d1;
      pix_data  <= disp_d1 ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// tb_vga_vram_arbiter
//   Directed bench for vga_vram_arbiter: drives timing-counter and host
//   stimulus, models the synchronous-read video RAM, and checks addresses,
//   pixel latency, host priority/ordering, range drops and reset behaviour.
module tb_vga_vram_arbiter;

  localparam int unsigned AW = 19;
  localparam int unsigned DW = 8;

  logic          ck = 1'b0;
  logic          reset;
  logic          active;
  logic [11:0]   position;
  logic          newline;
  logic          frame_start;
  logic          row_active;
  logic          host_valid;
  logic          host_ready;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_data;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic [2:0]    fifo_level;
  logic [7:0]    drop_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [0:(1<<AW)-1];

  vga_vram_arbiter #(
    .H_VISIBLE (800),
    .V_VISIBLE (600),
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .FIFO_DEPTH(4)
  ) dut (
    .ck         (ck),
    .reset      (reset),
    .active     (active),
    .position   (position),
    .newline    (newline),
    .frame_start(frame_start),
    .row_active (row_active),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_addr  (host_addr),
    .host_data  (host_data),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .fifo_level (fifo_level),
    .drop_count (drop_count)
  );

  always #5 ck = ~ck;

  // Single-port synchronous-read RAM.
  always @(posedge ck) begin
    if (mem_we)
      ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pat(input int unsigned a);
    return 8'((a * 37) ^ (a >> 9));
  endfunction

  // Advance to just after the next rising edge; inputs are set from here.
  task automatic cyc();
    @(posedge ck);
    #1;
  endtask

  task automatic set_vid(input logic a, input logic r, input int unsigned p,
                         input logic nl, input logic fs);
    active      = a;
    row_active  = r;
    position    = 12'(p);
    newline     = nl;
    frame_start = fs;
  endtask

  task automatic host(input logic v, input int unsigned a, input int unsigned d);
    host_valid = v;
    host_addr  = AW'(a);
    host_data  = DW'(d);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(); cyc(); #1;
    checks++;
    if (host_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || fifo_level !== 3'd0)
      begin errors++; $display("FAIL reset_hold: ready=%b we=%b addr=%0d lvl=%0d, want 0 0 0 0", host_ready, mem_we, mem_addr, fifo_level); end
    // three pushes during a display line
    for (int i = 0; i < 3; i++) begin
      cyc();
      reset = 1'b0;
      set_vid(1, 1, 10 + i, 0, 0);
      host(1, 7 + i, 1 + i);
      #1;
      if (i == 0) begin
        checks++;
        if (host_ready !== 1'b1)
          begin errors++; $display("FAIL ready_after_release: got %b want 1", host_ready); end
      end
    end
    cyc();
    set_vid(1, 1, 13, 0, 0);
    host(0, 0, 0);
    #1;
    checks++;
    if (fifo_level !== 3'd3)
      begin errors++; $display("FAIL level_before_reset: got %0d want 3", fifo_level); end
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== pat(11))
      begin errors++; $display("FAIL pix_before_reset: got v=%b d=%h want v=1 d=%h", pix_valid, pix_data, pat(11)); end
    // reset mid-line
    cyc();
    reset = 1'b1;
    set_vid(1, 1, 14, 0, 0);
    #1;
    checks++;
    if (host_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0)
      begin errors++; $display("FAIL reset_cycle: ready=%b we=%b addr=%0d want 0 0 0", host_ready, mem_we, mem_addr); end
    cyc();
    reset = 1'b0;
    set_vid(0, 0, 0, 0, 0);
    #1;
    checks++;
    if (fifo_level !== 3'd0 || pix_valid !== 1'b0 || pix_data !== 8'h00)
      begin errors++; $display("FAIL reset_flush: lvl=%0d pv=%b pd=%h want 0 0 00", fifo_level, pix_valid, pix_data); end
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== '0 || drop_count !== 8'd0 || host_ready !== 1'b1)
      begin errors++; $display("FAIL reset_after: we=%b addr=%0d drop=%0d ready=%b want 0 0 0 1", mem_we, mem_addr, drop_count, host_ready); end
  endtask

  task automatic test_addressing();
    logic pv1, pv2, disp, a, r, nl, fs;
    logic [7:0] pd1, pd2;
    int unsigned p, exp_addr;
    cyc(); set_vid(0, 0, 0, 0, 0);
    cyc(); set_vid(0, 0, 0, 0, 0);
    pv1 = 0; pv2 = 0; pd1 = '0; pd2 = '0;
    for (int l = 0; l < 2; l++) begin
      for (int j = 0; j < 804; j++) begin
        a = 0; r = 0; p = 0; nl = 0; fs = 0;
        if (j == 0) begin
          fs = (l == 0);
          r  = (l == 1);
        end else if (j <= 800) begin
          a = 1; r = 1; p = j - 1;
        end else if (j == 801) begin
          r = 1; nl = 1;
        end
        cyc();
        set_vid(a, r, p, nl, fs);
        #1;
        disp = a && r;
        exp_addr = disp ? (l * 800 + p) : 0;
        checks++;
        if (mem_addr !== AW'(exp_addr) || mem_we !== 1'b0)
          begin errors++; $display("FAIL addr line%0d step%0d: got addr=%0d we=%b want %0d 0", l, j, mem_addr, mem_we, exp_addr); end
        checks++;
        if (pix_valid !== pv2 || pix_data !== (pv2 ? pd2 : 8'h00))
          begin errors++; $display("FAIL pix line%0d step%0d: got v=%b d=%h want v=%b d=%h", l, j, pix_valid, pix_data, pv2, pv2 ? pd2 : 8'h00); end
        pv2 = pv1; pd2 = pd1;
        pv1 = disp; pd1 = pat(exp_addr);
      end
    end
  endtask

  task automatic test_priority();
    cyc(); set_vid(0, 1, 0, 0, 0); host(0, 0, 0);
    for (int j = 0; j < 800; j++) begin
      cyc();
      set_vid(1, 1, j, 0, 0);
      if (j < 12) host(1, 100 + j, 'h10 + j);
      else        host(0, 0, 0);
      #1;
      if (j < 4) begin
        checks++;
        if (host_ready !== 1'b1)
          begin errors++; $display("FAIL prio_ready_fill%0d: got %b want 1", j, host_ready); end
      end else if (j < 12) begin
        checks++;
        if (host_ready !== 1'b0)
          begin errors++; $display("FAIL prio_ready_full%0d: got %b want 0", j, host_ready); end
      end
      if (j == 4) begin
        checks++;
        if (fifo_level !== 3'd4)
          begin errors++; $display("FAIL prio_level_full: got %0d want 4", fifo_level); end
      end
      checks++;
      if (mem_we !== 1'b0)
        begin errors++; $display("FAIL prio_no_write pos%0d: got we=%b want 0", j, mem_we); end
    end
    for (int k = 0; k < 6; k++) begin
      cyc();
      set_vid(0, 1, 0, 0, 0);
      host(0, 0, 0);
      #1;
      checks++;
      if (k < 4) begin
        if (mem_we !== 1'b1 || mem_addr !== AW'(100 + k) || mem_wdata !== DW'('h10 + k))
          begin errors++; $display("FAIL prio_drain%0d: got we=%b addr=%0d data=%h want 1 %0d %h", k, mem_we, mem_addr, mem_wdata, 100 + k, 8'('h10 + k)); end
      end else begin
        if (mem_we !== 1'b0 || mem_addr !== '0 || fifo_level !== 3'd0)
          begin errors++; $display("FAIL prio_idle%0d: got we=%b addr=%0d lvl=%0d want 0 0 0", k, mem_we, mem_addr, fifo_level); end
      end
    end
  endtask

  task automatic test_coherency();
    cyc(); set_vid(0, 0, 0, 0, 0); host(1, 5, 'hAB); #1;
    checks++;
    if (host_ready !== 1'b1 || mem_we !== 1'b0)
      begin errors++; $display("FAIL coh_push: ready=%b we=%b want 1 0", host_ready, mem_we); end
    cyc(); host(0, 0, 0); #1;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== AW'(5) || mem_wdata !== 8'hAB)
      begin errors++; $display("FAIL coh_drain: we=%b addr=%0d data=%h want 1 5 ab", mem_we, mem_addr, mem_wdata); end
    cyc(); set_vid(0, 0, 0, 0, 1);
    for (int p = 0; p < 8; p++) begin
      cyc();
      set_vid(1, 1, p, 0, 0);
      #1;
      if (p == 5) begin
        checks++;
        if (mem_addr !== AW'(5))
          begin errors++; $display("FAIL coh_read_addr: got %0d want 5", mem_addr); end
      end
      if (p == 6) begin
        checks++;
        if (pix_valid !== 1'b1 || pix_data !== pat(4))
          begin errors++; $display("FAIL coh_neighbour: got v=%b d=%h want 1 %h", pix_valid, pix_data, pat(4)); end
      end
      if (p == 7) begin
        checks++;
        if (pix_valid !== 1'b1 || pix_data !== 8'hAB)
          begin errors++; $display("FAIL coh_pixel: got v=%b d=%h want 1 ab", pix_valid, pix_data); end
      end
    end
  endtask

  task automatic test_out_of_range();
    cyc(); set_vid(0, 0, 0, 0, 0); host(1, 480000, 'h11); #1;
    cyc(); host(1, 524287, 'h22); #1;
    checks++;
    if (mem_we !== 1'b0 || fifo_level !== 3'd1)
      begin errors++; $display("FAIL oor_drop1: we=%b lvl=%0d want 0 1", mem_we, fifo_level); end
    cyc(); host(0, 0, 0); #1;
    checks++;
    if (mem_we !== 1'b0 || drop_count !== 8'd1)
      begin errors++; $display("FAIL oor_drop2: we=%b drop=%0d want 0 1", mem_we, drop_count); end
    cyc(); #1;
    checks++;
    if (drop_count !== 8'd2 || fifo_level !== 3'd0)
      begin errors++; $display("FAIL oor_count: drop=%0d lvl=%0d want 2 0", drop_count, fifo_level); end
    // last in-range address
    cyc(); host(1, 479999, 'h5A); #1;
    cyc(); host(0, 0, 0); #1;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== AW'(479999) || mem_wdata !== 8'h5A)
      begin errors++; $display("FAIL oor_edge_write: we=%b addr=%0d data=%h want 1 479999 5a", mem_we, mem_addr, mem_wdata); end
    cyc(); #1;
    checks++;
    if (drop_count !== 8'd2)
      begin errors++; $display("FAIL oor_edge_nodrop: drop=%0d want 2", drop_count); end
    for (int i = 0; i < 300; i++) begin
      cyc();
      host(1, 480000 + i, i);
      #1;
      if (i > 0) begin
        checks++;
        if (mem_we !== 1'b0)
          begin errors++; $display("FAIL oor_bulk_we%0d: got %b want 0", i, mem_we); end
      end
      if (i == 100 || i == 254 || i == 260) begin
        checks++;
        if (drop_count !== ((i == 100) ? 8'd101 : 8'd255))
          begin errors++; $display("FAIL oor_bulk_count%0d: got %0d want %0d", i, drop_count, (i == 100) ? 101 : 255); end
      end
    end
    cyc(); host(0, 0, 0);
    cyc(); cyc(); #1;
    checks++;
    if (drop_count !== 8'd255 || fifo_level !== 3'd0)
      begin errors++; $display("FAIL oor_saturate: drop=%0d lvl=%0d want 255 0", drop_count, fifo_level); end
  endtask

  task automatic test_simultaneous();
    cyc(); set_vid(0, 1, 0, 1, 0); host(0, 0, 0);
    cyc(); set_vid(1, 1, 3, 0, 0); #1;
    checks++;
    if (mem_addr !== AW'(803))
      begin errors++; $display("FAIL sim_newline_step: got %0d want 803", mem_addr); end
    cyc(); set_vid(0, 0, 0, 1, 0);
    cyc(); set_vid(1, 1, 0, 0, 0); #1;
    checks++;
    if (mem_addr !== AW'(800))
      begin errors++; $display("FAIL sim_newline_blank_row: got %0d want 800", mem_addr); end
    cyc(); set_vid(0, 1, 0, 1, 1);
    cyc(); set_vid(1, 1, 0, 0, 0); #1;
    checks++;
    if (mem_addr !== '0)
      begin errors++; $display("FAIL sim_fs_nl: got %0d want 0", mem_addr); end
    // level 2, then push and pop in the same cycle
    cyc(); set_vid(1, 1, 1, 0, 0); host(1, 200, 'h20);
    cyc(); set_vid(1, 1, 2, 0, 0); host(1, 201, 'h21);
    cyc(); set_vid(0, 1, 0, 0, 0); host(1, 202, 'h22); #1;
    checks++;
    if (fifo_level !== 3'd2 || host_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(200) || mem_wdata !== 8'h20)
      begin errors++; $display("FAIL sim_pushpop: lvl=%0d ready=%b we=%b addr=%0d data=%h want 2 1 1 200 20", fifo_level, host_ready, mem_we, mem_addr, mem_wdata); end
    cyc(); set_vid(1, 1, 3, 0, 0); host(0, 0, 0); #1;
    checks++;
    if (fifo_level !== 3'd2)
      begin errors++; $display("FAIL sim_level_kept: got %0d want 2", fifo_level); end
    // fill, then offer a write while full and draining
    cyc(); set_vid(1, 1, 4, 0, 0); host(1, 203, 'h23);
    cyc(); set_vid(1, 1, 5, 0, 0); host(1, 204, 'h24);
    cyc(); set_vid(1, 1, 6, 0, 0); host(0, 0, 0); #1;
    checks++;
    if (fifo_level !== 3'd4 || host_ready !== 1'b0)
      begin errors++; $display("FAIL sim_full: lvl=%0d ready=%b want 4 0", fifo_level, host_ready); end
    cyc(); set_vid(0, 1, 0, 0, 0); host(1, 205, 'h25); #1;
    checks++;
    if (host_ready !== 1'b0 || mem_we !== 1'b1 || mem_addr !== AW'(201))
      begin errors++; $display("FAIL sim_full_pop: ready=%b we=%b addr=%0d want 0 1 201", host_ready, mem_we, mem_addr); end
    for (int k = 0; k < 4; k++) begin
      cyc(); host(0, 0, 0); #1;
      if (k == 0) begin
        checks++;
        if (fifo_level !== 3'd3)
          begin errors++; $display("FAIL sim_no_push_full: lvl=%0d want 3", fifo_level); end
      end
      checks++;
      if (k < 3) begin
        if (mem_we !== 1'b1 || mem_addr !== AW'(202 + k) || mem_wdata !== DW'('h22 + k))
          begin errors++; $display("FAIL sim_order%0d: we=%b addr=%0d data=%h want 1 %0d %h", k, mem_we, mem_addr, mem_wdata, 202 + k, 8'('h22 + k)); end
      end else begin
        if (mem_we !== 1'b0 || mem_addr !== '0 || fifo_level !== 3'd0)
          begin errors++; $display("FAIL sim_end_idle: we=%b addr=%0d lvl=%0d want 0 0 0", mem_we, mem_addr, fifo_level); end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    set_vid(0, 0, 0, 0, 0);
    host(0, 0, 0);
    for (int unsigned i = 0; i < (1 << AW); i++)
      ram[i] = pat(i);
    test_reset();
    test_addressing();
    test_priority();
    test_coherency();
    test_out_of_range();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_vram_arbiter.md
# vga_vram_arbiter

Shares one single-port, synchronous-read video RAM between two requesters:
- **Display fetch path:** driven by the horizontal/vertical timing counters. It has absolute priority.
- **Host write port:** buffered in a small FIFO and drained only in cycles the display does not need the memory.

The block sits between the timing counters and the video RAM. It turns `position`/line progress into linear pixel addresses and delivers pixel data with a fixed latency.

## Interface

Parameters:
- `H_VISIBLE`, 800, visible pixels per line
- `V_VISIBLE`, 600, visible lines per frame
- `DATA_W`, 8, pixel width
- `ADDR_W`, 19, memory address width; must satisfy 2^ADDR_W >= H_VISIBLE*V_VISIBLE
- `FIFO_DEPTH`, 4, host write FIFO entries (power of two)

Ports:
- `ck`  in  1  clock; one clock domain
- `reset`  in  1  synchronous, active-high reset
- `active`  in  1  horizontal visible-area flag from the timing counter
- `position`  in  12  horizontal pixel index, valid while `active`=1
- `newline`  in  1  one-cycle pulse at end of each line
- `frame_start`  in  1  one-cycle pulse before the first line of a frame
- `row_active`  in  1  current line is inside the vertical visible area
- `host_valid`  in  1  host write request
- `host_ready`  out  1  FIFO can accept; equals !full, forced 0 during reset
- `host_addr`  in  ADDR_W  host write address
- `host_data`  in  DATA_W  host write data
- `mem_addr`  out  ADDR_W  RAM address
- `mem_we`  out  1  RAM write enable
- `mem_wdata`  out  DATA_W  RAM write data
- `mem_rdata`  in  DATA_W  RAM read data, valid one cycle after the address
- `pix_data`  out  DATA_W  pixel to the DAC stage
- `pix_valid`  out  1  `pix_data` corresponds to a visible pixel
- `fifo_level`  out  log2(FIFO_DEPTH)+1  current FIFO occupancy
- `drop_count`  out  8  saturating count of discarded out-of-range host writes

## Operation

**Display slot**
- A cycle is a display slot when `active`=1 and `row_active`=1.
- In a display slot: `mem_addr` = `line_base` + `position`, `mem_we`=0. Address arithmetic is ADDR_W bits wide, with `position` zero-extended.

**`line_base` register (ADDR_W bits)**
- Cleared on `frame_start`.
- On `newline` with `row_active`=1, `line_base` += H_VISIBLE. `row_active` sampled in the `newline` cycle refers to the line just finished.
- If `frame_start` and `newline` occur in the same cycle, `frame_start` wins (`line_base`=0).

**Host FIFO**
- Push when `host_valid` && `host_ready`.
- No push when full, even if a pop happens in the same cycle.
- Push and pop in the same cycle are allowed when not full; `fifo_level` is then unchanged.

**Drain**
- In any non-display slot with the FIFO non-empty, pop the head entry.
- If head addr < H_VISIBLE*V_VISIBLE: drive `mem_addr`=addr, `mem_wdata`=data, `mem_we`=1.
- Otherwise: `mem_we`=0 and `drop_count` increments, saturating at 255.
- Exactly one pop per drain cycle.

**Idle**
- Non-display slot with an empty FIFO: `mem_we`=0, `mem_addr`=0.

**Registering and ordering**
- `mem_addr`, `mem_we` and `mem_wdata` are combinational from the current slot decision and FIFO head.
- Writes drain in FIFO order.
- A display read never observes a host write still sitting in the FIFO.

**Reset** (synchronous, any cycle, including mid-drain or mid-line)
- FIFO emptied, `line_base`=0, `drop_count`=0.
- `pix_data`=0, `pix_valid`=0, `fifo_level`=0, `host_ready`=0.
- `mem_we`=0 and `mem_addr`=0 in the reset cycle.
- `host_ready` returns to 1 in the first cycle after `reset` deasserts.

## Timing

**Pixel path**
- Display read issued in cycle t.
- `mem_rdata` is valid in t+1 and is registered into `pix_data` at the end of t+1.
- `pix_data`/`pix_valid` are visible in t+2. Fixed latency is 2 cycles.
- `pix_valid` is the display-slot flag delayed 2 cycles.
- When `pix_valid`=0, `pix_data` is 0.

**Host path**
- An entry pushed in cycle t is eligible to drain in cycle t+1 at the earliest.
- Worst-case wait is bounded by one visible line (H_VISIBLE cycles) plus FIFO_DEPTH-1 earlier entries.
- `host_ready` is low in the cycle the FIFO holds FIFO_DEPTH entries.
- `fifo_level` updates one cycle after each push/pop.

**Throughput**
- During display slots the host drains nothing; the FIFO can fill and back-pressure the host.
- In any non-display stretch the FIFO drains at one entry per cycle.

## Test plan

- **Reset:** assert `reset` mid-line with 3 FIFO entries -> next cycle `fifo_level`=0, `pix_valid`=0, `mem_we`=0, `drop_count`=0; `host_ready`=1 one cycle after release.
- **Addressing:** `frame_start`, then line 0 active with `position` 0..799, `newline` with `row_active`=1, then line 1 -> `mem_addr` runs 0..799 then 800..1599; `pix_data` equals RAM contents with 2-cycle latency and `pix_valid` aligned.
- **Priority:** push 4 host writes at the start of an active line -> `host_ready` drops after the 4th, `mem_we` stays 0 for all 800 active cycles, then the 4 writes are issued on 4 consecutive blanking cycles in push order.
- **Coherency:** host writes 0xAB to address 5 during blanking, next line reads `position` 5 -> `pix_data`=0xAB.
- **Out-of-range:** write to address 480000 and 524287 during blanking -> no `mem_we`, `drop_count`=2; 300 such writes -> `drop_count` saturates at 255.
- **Simultaneous events:** `frame_start` and `newline` in the same cycle with `row_active`=1 -> next line's first address is 0; push and pop in the same cycle at level 2 -> `fifo_level` stays 2.
